new_game_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 62 ++++++
 rtl/new_game_ctrl.sv | 94 +++++++++
 tb/tb_new_game_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and timing defaults for the game-session controller
package game_pkg;

    typedef enum logic [1:0] {
        GAME_IDLE     = 2'd0,
        GAME_STARTING = 2'd1,
        GAME_RUNNING  = 2'd2,
        GAME_OVER     = 2'd3
    } game_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES      = 1_000_000;
    localparam int DEFAULT_AUTO_RESTART         = 0;
    localparam int DEFAULT_RESTART_DELAY_CYCLES = 200_000_000;

    // Counter width for a cycle count; keeps at least one bit so a count of 1 still elaborates.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, level debouncer and rising-edge detector
module btn_debounce
    import game_pkg::*;
#(
    parameter int DebounceCycles = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int              CW       = cnt_width(DebounceCycles);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DebounceCycles - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic          sync_a;
    logic          sync_q;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_a <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            sync_a <= btn_i;
            sync_q <= sync_a;
        end
    end

    // Accept a new level only after it has differed from stable for DebounceCycles samples in a row.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync_q == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync_q;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Previous debounced level, used to find the single-cycle rising edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stable_d <= 1'b0;
        end else begin
            stable_d <= stable;
        end
    end

    assign level_o = stable;
    assign rise_o  = stable & ~stable_d;

endmodule

// File: rtl/new_game_ctrl.sv
// rtl/new_game_ctrl.sv - game lifecycle FSM issuing one-cycle new-game requests to the start-line timer
module new_game_ctrl
    import game_pkg::*;
#(
    parameter int DebounceCycles     = DEFAULT_DEBOUNCE_CYCLES,
    parameter int AutoRestart        = DEFAULT_AUTO_RESTART,
    parameter int RestartDelayCycles = DEFAULT_RESTART_DELAY_CYCLES
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_start_i,
    input  logic       game_over_i,
    input  logic       line_type_i,
    output logic       new_game_o,
    output logic [1:0] game_state_o,
    output logic [7:0] game_count_o
);

    localparam int            TW       = cnt_width(RestartDelayCycles);
    localparam logic [TW-1:0] TMR_LAST = TW'(RestartDelayCycles - 1);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);

    game_state_t   state;
    logic          seen_low;
    logic [TW-1:0] timer;
    logic          press;
    logic          btn_level_unused;
    logic          restart_due;
    logic          start_game;

    btn_debounce #(
        .DebounceCycles (DebounceCycles)
    ) u_btn_debounce (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (btn_start_i),
        .level_o (btn_level_unused),
        .rise_o  (press)
    );

    // Presses only count in IDLE and OVER; the auto-restart timer only matters in OVER.
    assign restart_due = (AutoRestart != 0) && (timer == TMR_LAST);
    assign start_game  = ((state == GAME_IDLE) && press) ||
                         ((state == GAME_OVER) && (press || restart_due));

    // Lifecycle FSM with registered request pulse and game counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= GAME_IDLE;
            new_game_o   <= 1'b0;
            game_count_o <= 8'd0;
            seen_low     <= 1'b0;
            timer        <= '0;
        end else begin
            new_game_o <= 1'b0;
            if (start_game) begin
                // A press and a timer expiry in the same cycle still make a single request.
                state        <= GAME_STARTING;
                seen_low     <= 1'b0;
                new_game_o   <= 1'b1;
                game_count_o <= game_count_o + 8'd1;
            end else begin
                case (state)
                    GAME_IDLE: begin
                        state <= GAME_IDLE;
                    end
                    GAME_STARTING: begin
                        // The line must be seen low first so a stale high from the last race is ignored.
                        if (line_type_i && seen_low) begin
                            state <= GAME_RUNNING;
                        end else if (!line_type_i) begin
                            seen_low <= 1'b1;
                        end
                    end
                    GAME_RUNNING: begin
                        if (game_over_i) begin
                            state <= GAME_OVER;
                            timer <= '0;
                        end
                    end
                    GAME_OVER: begin
                        timer <= timer + TMR_ONE;
                    end
                    default: begin
                        state <= GAME_IDLE;
                    end
                endcase
            end
        end
    end

    assign game_state_o = state;

endmodule

// File: tb/tb_new_game_ctrl.sv
// tb/tb_new_game_ctrl.sv - bench for new_game_ctrl with and without auto-restart
module tb_new_game_ctrl;

    localparam int DB = 4;
    localparam int RD = 20;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_STARTING = 2'd1;
    localparam logic [1:0] S_RUNNING  = 2'd2;
    localparam logic [1:0] S_OVER     = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_btn, a_go, a_lt, a_ng;
    logic [1:0] a_st;
    logic [7:0] a_cnt;
    logic       b_rst, b_btn, b_go, b_lt, b_ng;
    logic [1:0] b_st;
    logic [7:0] b_cnt;

    new_game_ctrl #(
        .DebounceCycles     (DB),
        .AutoRestart        (0),
        .RestartDelayCycles (RD)
    ) dut_a (
        .clk_i        (clk),
        .rst_i        (a_rst),
        .btn_start_i  (a_btn),
        .game_over_i  (a_go),
        .line_type_i  (a_lt),
        .new_game_o   (a_ng),
        .game_state_o (a_st),
        .game_count_o (a_cnt)
    );

    new_game_ctrl #(
        .DebounceCycles     (DB),
        .AutoRestart        (1),
        .RestartDelayCycles (RD)
    ) dut_b (
        .clk_i        (clk),
        .rst_i        (b_rst),
        .btn_start_i  (b_btn),
        .game_over_i  (b_go),
        .line_type_i  (b_lt),
        .new_game_o   (b_ng),
        .game_state_o (b_st),
        .game_count_o (b_cnt)
    );

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    // Reference model: the debounced level flips once the last DB synchronized samples all
    // disagree with it; a press is the cycle after it flips to 1.
    typedef struct packed {
        logic        s1;
        logic        s2;
        logic        stable;
        logic        rose;
        logic [7:0]  hist;
        logic [1:0]  st;
        logic        seen;
        logic [31:0] timer;
        logic [7:0]  count;
        logic        pulse;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mstep(input mdl_t m, input bit ar, input logic btn,
                                   input logic go, input logic lt, input logic rst);
        mdl_t n;
        logic press;
        logic [7:0] mask;
        n = m;
        if (rst) begin
            n = '0;
            return n;
        end
        press   = m.rose;
        n.pulse = 1'b0;
        case (m.st)
            S_IDLE:     if (press) begin n.st = S_STARTING; n.seen = 1'b0; n.pulse = 1'b1; end
            S_STARTING: if (lt && m.seen) n.st = S_RUNNING; else if (!lt) n.seen = 1'b1;
            S_RUNNING:  if (go) begin n.st = S_OVER; n.timer = 0; end
            default: begin
                if (press || (ar && m.timer == RD - 1)) begin
                    n.st = S_STARTING; n.seen = 1'b0; n.pulse = 1'b1;
                end else begin
                    n.timer = m.timer + 1;
                end
            end
        endcase
        if (n.pulse) n.count = m.count + 8'd1;
        mask   = 8'((1 << DB) - 1);
        n.hist = {m.hist[6:0], m.s2};
        n.rose = 1'b0;
        if (!m.stable && ((n.hist & mask) == mask)) begin
            n.stable = 1'b1;
            n.rose   = 1'b1;
        end else if (m.stable && ((n.hist & mask) == 8'd0)) begin
            n.stable = 1'b0;
        end
        n.s2 = m.s1;
        n.s1 = btn;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        ma = mstep(ma, 1'b0, a_btn, a_go, a_lt, a_rst);
        mb = mstep(mb, 1'b1, b_btn, b_go, b_lt, b_rst);
        edge_n++;
        #1;
        chk("a_new_game", a_ng, ma.pulse);
        chk("a_state", a_st, ma.st);
        chk("a_count", a_cnt, ma.count);
        chk("b_new_game", b_ng, mb.pulse);
        chk("b_state", b_st, mb.st);
        chk("b_count", b_cnt, mb.count);
    endtask

    typedef struct {
        logic       btn;
        logic       go;
        logic       lt;
        int         n;
        logic [1:0] st;
        logic [7:0] cnt;
        int         pulses;
        string      name;
    } seg_t;

    seg_t segs[$];

    function automatic seg_t mk(input logic btn, input logic go, input logic lt, input int n,
                                input logic [1:0] st, input logic [7:0] cnt, input int pulses,
                                input string name);
        seg_t s;
        s.btn = btn; s.go = go; s.lt = lt; s.n = n;
        s.st = st; s.cnt = cnt; s.pulses = pulses; s.name = name;
        return s;
    endfunction

    task automatic run_segs();
        int p;
        foreach (segs[i]) begin
            a_btn = segs[i].btn; a_go = segs[i].go; a_lt = segs[i].lt;
            p = 0;
            for (int c = 0; c < segs[i].n; c++) begin
                step();
                if (a_ng === 1'b1) p++;
            end
            chk({segs[i].name, "_state"}, a_st, segs[i].st);
            chk({segs[i].name, "_count"}, a_cnt, segs[i].cnt);
            chk({segs[i].name, "_pulses"}, p, segs[i].pulses);
        end
        segs.delete();
    endtask

    task automatic b_start_from_idle();
        int seen;
        seen = 0;
        b_btn = 1'b1;
        for (int c = 0; c < 12 && seen == 0; c++) begin
            step();
            if (b_ng === 1'b1) seen = 1;
        end
        chk("b_idle_press", seen, 1);
        b_btn = 1'b0;
        for (int c = 0; c < 8; c++) step();
    endtask

    // One auto-restarted game: STARTING -> RUNNING -> OVER -> pulse exactly RD cycles after OVER entry.
    task automatic b_game(input int press_k);
        int pulses, first_k;
        b_lt = 1'b0; step();
        b_lt = 1'b1; step();
        chk("b_running", b_st, S_RUNNING);
        b_go = 1'b1; step();
        b_go = 1'b0;
        chk("b_over", b_st, S_OVER);
        pulses = 0; first_k = 0;
        for (int k = 1; k <= 25; k++) begin
            if (press_k != 0 && k == press_k) b_btn = 1'b1;
            step();
            if (b_ng === 1'b1) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
        end
        chk("b_pulses", pulses, 1);
        chk("b_restart_delay", first_k, RD);
        chk("b_restarted", b_st, S_STARTING);
        if (press_k != 0) begin
            b_btn = 1'b0;
            for (int c = 0; c < 8; c++) step();
        end
    endtask

    initial begin
        int ref_e, first_e, p;
        logic [7:0] cnt_before;
        ma = '0; mb = '0;
        a_rst = 1'b1; a_btn = 1'b0; a_go = 1'b0; a_lt = 1'b0;
        b_rst = 1'b1; b_btn = 1'b0; b_go = 1'b0; b_lt = 1'b0;
        step();
        a_rst = 1'b0; b_rst = 1'b0;
        chk("reset_state", a_st, S_IDLE);
        chk("reset_count", a_cnt, 8'd0);
        chk("reset_pulse", a_ng, 1'b0);

        // Short bounces never become a press.
        segs.push_back(mk(1, 0, 0, 3, S_IDLE, 0, 0, "bounce_hi1"));
        segs.push_back(mk(0, 0, 0, 3, S_IDLE, 0, 0, "bounce_lo1"));
        segs.push_back(mk(1, 0, 0, 3, S_IDLE, 0, 0, "bounce_hi2"));
        segs.push_back(mk(0, 0, 0, 8, S_IDLE, 0, 0, "bounce_lo2"));
        run_segs();

        // Button held from edge 10 after reset: pulse after edge 16.
        a_lt = 1'b1;
        a_rst = 1'b1; step(); a_rst = 1'b0;
        ref_e = edge_n;
        for (int c = 0; c < 9; c++) step();
        a_btn = 1'b1;
        first_e = -1; p = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (a_ng === 1'b1) begin
                p++;
                if (first_e < 0) first_e = edge_n - ref_e;
            end
        end
        chk("hold_pulse_edge", first_e, 16);
        chk("hold_pulses", p, 1);
        chk("hold_state", a_st, S_STARTING);
        chk("hold_count", a_cnt, 8'd1);

        segs.push_back(mk(1, 0, 1, 8, S_STARTING, 1, 0, "stale_line"));
        segs.push_back(mk(0, 0, 1, 8, S_STARTING, 1, 0, "release"));
        segs.push_back(mk(1, 0, 1, 8, S_STARTING, 1, 0, "press_in_starting"));
        segs.push_back(mk(0, 0, 0, 8, S_STARTING, 1, 0, "line_low"));
        segs.push_back(mk(0, 0, 1, 1, S_RUNNING,  1, 0, "line_high"));
        segs.push_back(mk(1, 0, 1, 6, S_RUNNING,  1, 0, "press_arm"));
        segs.push_back(mk(1, 1, 1, 1, S_OVER,     1, 0, "over_with_press"));
        segs.push_back(mk(1, 0, 1, 5, S_OVER,     1, 0, "over_hold"));
        segs.push_back(mk(0, 0, 1, 8, S_OVER,     1, 0, "over_release"));
        segs.push_back(mk(1, 0, 1, 8, S_STARTING, 2, 1, "over_press"));
        run_segs();
        a_btn = 1'b0; a_lt = 1'b0;

        // Auto-restart, with a press landing on the expiry cycle.
        b_rst = 1'b1; step(); b_rst = 1'b0;
        b_start_from_idle();
        b_game(RD - 2 * DB + 2);
        chk("b_coincide_count", b_cnt, 8'd2);

        // 256 games from reset wrap the count to 0; then reset from RUNNING at 255.
        b_rst = 1'b1; step(); b_rst = 1'b0;
        b_start_from_idle();
        for (int g = 0; g < 255; g++) b_game(0);
        chk("wrap_count", b_cnt, 8'd0);
        for (int g = 0; g < 255; g++) b_game(0);
        b_lt = 1'b0; step();
        b_lt = 1'b1; step();
        chk("pre_reset_state", b_st, S_RUNNING);
        chk("pre_reset_count", b_cnt, 8'd255);
        b_rst = 1'b1; step(); b_rst = 1'b0;
        chk("mid_reset_state", b_st, S_IDLE);
        chk("mid_reset_count", b_cnt, 8'd0);

        // Random traffic on both instances against the model.
        cnt_before = 8'd0;
        for (int c = 0; c < 3000; c++) begin
            a_rst = ($urandom_range(0, 399) == 0);
            b_rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 5) == 0) a_btn = ~a_btn;
            if ($urandom_range(0, 5) == 0) b_btn = ~b_btn;
            if ($urandom_range(0, 3) == 0) a_lt = ~a_lt;
            if ($urandom_range(0, 3) == 0) b_lt = ~b_lt;
            a_go = ($urandom_range(0, 9) == 0);
            b_go = ($urandom_range(0, 9) == 0);
            step();
            chk("no_back_to_back", (a_ng === 1'b1) && (cnt_before == 8'hFF), 1'b0);
            cnt_before = (a_ng === 1'b1) ? 8'hFF : 8'h00;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
